// File: rtl/preset_loader.sv
// BCD preset loader: captures a parallel or keypad-entered preset, checks it is
// valid BCD, then holds registered set/reset masks on the counter for PULSE_CYCLES.
module preset_loader #(
  parameter int DIGITS       = 4,
  parameter int PULSE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  permit,
  input  logic                  mode,
  input  logic [4*DIGITS-1:0]   values,
  input  logic [3:0]            digit_in,
  input  logic                  digit_valid,
  input  logic                  clear_entry,
  output logic [4*DIGITS-1:0]   set,
  output logic [4*DIGITS-1:0]   reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [4*DIGITS-1:0]   shadow
);

  localparam int W = 4 * DIGITS;
  localparam logic [3:0] PULSE_INIT = 4'(PULSE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_DRIVE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [W-1:0]   stage_q, stage_d;
  logic           src_serial_q, src_serial_d;
  logic [W-1:0]   shadow_q, shadow_d;
  logic [W-1:0]   set_q, set_d;
  logic [W-1:0]   reset_q, reset_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           error_q, error_d;

  function automatic logic all_bcd(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [W-1:0] shift_digit(input logic [W-1:0] cur,
                                                input logic [3:0]   dig);
    return (cur << 4) | W'(dig);
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stage_d      = stage_q;
    src_serial_d = src_serial_q;
    shadow_d     = shadow_q;
    error_d      = error_q;

    unique case (state_q)
      S_IDLE: begin
        // A load request outranks keypad activity arriving in the same cycle.
        if (permit) begin
          state_d      = S_CHECK;
          stage_d      = mode ? shadow_q : values;
          src_serial_d = mode;
          error_d      = 1'b0;
        end else if (clear_entry) begin
          shadow_d = '0;
        end else if (digit_valid) begin
          shadow_d = shift_digit(shadow_q, digit_in);
        end
      end
      S_CHECK: begin
        if (!all_bcd(stage_q)) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_DRIVE;
          cnt_d   = PULSE_INIT;
        end
      end
      S_DRIVE: begin
        if (cnt_q <= 4'd1) begin
          state_d = S_DONE;
        end else begin
          cnt_d = 4'(cnt_q - 4'd1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (src_serial_q) shadow_d = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    set_d   = (state_d == S_DRIVE) ? stage_d  : '0;
    reset_d = (state_d == S_DRIVE) ? ~stage_d : '0;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      src_serial_q <= 1'b0;
      shadow_q     <= '0;
      set_q        <= '0;
      reset_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      src_serial_q <= src_serial_d;
      shadow_q     <= shadow_d;
      set_q        <= set_d;
      reset_q      <= reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  // Staged preset is pure data; it is always rewritten before it is used.
  always_ff @(posedge clk) begin
    stage_q <= stage_d;
  end

  assign set    = set_q;
  assign reset  = reset_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign error  = error_q;
  assign shadow = shadow_q;

endmodule

// File: tb/tb_preset_loader.sv
// Directed bench for preset_loader: parallel, serial, invalid BCD, busy
// priority, asynchronous reset mid-drive and a DIGITS=6/PULSE_CYCLES=1 build.
module tb_preset_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        permit = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] values = '0;
  logic [3:0]  digit_in = '0;
  logic        digit_valid = 1'b0;
  logic        clear_entry = 1'b0;
  logic [15:0] set_o, reset_o, shadow_o;
  logic        busy_o, done_o, error_o;

  logic        pb = 1'b0;
  logic        mb = 1'b0;
  logic [23:0] vb = '0;
  logic [3:0]  db = '0;
  logic        dvb = 1'b0;
  logic        ceb = 1'b0;
  logic [23:0] set_b, reset_b, shadow_b;
  logic        busy_b, done_b, error_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  preset_loader #(.DIGITS(4), .PULSE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .permit(permit), .mode(mode), .values(values),
    .digit_in(digit_in), .digit_valid(digit_valid), .clear_entry(clear_entry),
    .set(set_o), .reset(reset_o), .busy(busy_o), .done(done_o),
    .error(error_o), .shadow(shadow_o)
  );

  preset_loader #(.DIGITS(6), .PULSE_CYCLES(1)) dut6 (
    .clk(clk), .rst_n(rst_n), .permit(pb), .mode(mb), .values(vb),
    .digit_in(db), .digit_valid(dvb), .clear_entry(ceb),
    .set(set_b), .reset(reset_b), .busy(busy_b), .done(done_b),
    .error(error_b), .shadow(shadow_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic enter_digit(input logic [3:0] d);
    digit_in    = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_set", 32'(set_o), 32'h0);
    chk("rst_reset", 32'(reset_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_error", 32'(error_o), 32'h0);
    chk("rst_shadow", 32'(shadow_o), 32'h0);
    #20 rst_n = 1'b1;
    tick();

    // Parallel load 1234
    values = 16'h1234; mode = 1'b0; permit = 1'b1;
    tick();
    permit = 1'b0;
    chk("par_c1_busy", 32'(busy_o), 32'h1);
    chk("par_c1_set", 32'(set_o), 32'h0);
    chk("par_c1_done", 32'(done_o), 32'h0);
    values = 16'h9999;
    tick();
    chk("par_c2_set", 32'(set_o), 32'h1234);
    chk("par_c2_reset", 32'(reset_o), 32'hEDCB);
    chk("par_c2_busy", 32'(busy_o), 32'h1);
    tick();
    chk("par_c3_set", 32'(set_o), 32'h1234);
    chk("par_c3_reset", 32'(reset_o), 32'hEDCB);
    chk("par_c3_done", 32'(done_o), 32'h0);
    tick();
    chk("par_c4_set", 32'(set_o), 32'h0);
    chk("par_c4_reset", 32'(reset_o), 32'h0);
    chk("par_c4_done", 32'(done_o), 32'h1);
    chk("par_c4_busy", 32'(busy_o), 32'h1);
    tick();
    chk("par_c5_done", 32'(done_o), 32'h0);
    chk("par_c5_busy", 32'(busy_o), 32'h0);

    // Serial entry 5,9,0,7 then load from shadow
    enter_digit(4'd5);
    enter_digit(4'd9);
    enter_digit(4'd0);
    enter_digit(4'd7);
    chk("ser_shadow", 32'(shadow_o), 32'h5907);
    mode = 1'b1; permit = 1'b1;
    tick();
    permit = 1'b0; mode = 1'b0;
    chk("ser_c1_busy", 32'(busy_o), 32'h1);
    tick();
    chk("ser_c2_set", 32'(set_o), 32'h5907);
    chk("ser_c2_reset", 32'(reset_o), 32'hA6F8);
    // Requests during DRIVE must be ignored
    permit = 1'b1; digit_valid = 1'b1; digit_in = 4'd4; clear_entry = 1'b1;
    tick();
    chk("busy_c3_shadow", 32'(shadow_o), 32'h5907);
    chk("busy_c3_set", 32'(set_o), 32'h5907);
    tick();
    permit = 1'b0; digit_valid = 1'b0; clear_entry = 1'b0;
    chk("ser_c4_done", 32'(done_o), 32'h1);
    tick();
    chk("ser_c5_done", 32'(done_o), 32'h0);
    chk("ser_c5_busy", 32'(busy_o), 32'h0);
    chk("ser_c5_shadow", 32'(shadow_o), 32'h0);
    tick();
    chk("ser_c6_done", 32'(done_o), 32'h0);
    chk("ser_c6_busy", 32'(busy_o), 32'h0);

    // Overflow discards the top digit
    enter_digit(4'd5);
    enter_digit(4'd9);
    enter_digit(4'd0);
    enter_digit(4'd7);
    enter_digit(4'd3);
    chk("ovf_shadow", 32'(shadow_o), 32'h9073);
    // clear beats digit_valid
    clear_entry = 1'b1; digit_valid = 1'b1; digit_in = 4'd1;
    tick();
    clear_entry = 1'b0; digit_valid = 1'b0;
    chk("clr_prio_shadow", 32'(shadow_o), 32'h0);

    // Invalid BCD
    values = 16'h12A4; permit = 1'b1;
    tick();
    permit = 1'b0;
    chk("inv_c1_busy", 32'(busy_o), 32'h1);
    chk("inv_c1_error", 32'(error_o), 32'h0);
    tick();
    chk("inv_c2_error", 32'(error_o), 32'h1);
    chk("inv_c2_busy", 32'(busy_o), 32'h0);
    chk("inv_c2_set", 32'(set_o), 32'h0);
    chk("inv_c2_reset", 32'(reset_o), 32'h0);
    tick();
    chk("inv_c3_done", 32'(done_o), 32'h0);
    chk("inv_c3_set", 32'(set_o), 32'h0);
    chk("inv_c3_error", 32'(error_o), 32'h1);
    // Follow-up load of 0000 clears error
    values = 16'h0000; permit = 1'b1;
    tick();
    permit = 1'b0;
    chk("fu_c1_error", 32'(error_o), 32'h0);
    tick();
    chk("fu_c2_reset", 32'(reset_o), 32'hFFFF);
    chk("fu_c2_set", 32'(set_o), 32'h0);
    tick();
    tick();
    chk("fu_c4_done", 32'(done_o), 32'h1);
    tick();

    // Asynchronous reset during DRIVE
    values = 16'h1234; permit = 1'b1;
    tick();
    permit = 1'b0;
    tick();
    chk("ar_c2_set", 32'(set_o), 32'h1234);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_set", 32'(set_o), 32'h0);
    chk("ar_reset", 32'(reset_o), 32'h0);
    chk("ar_busy", 32'(busy_o), 32'h0);
    #2 rst_n = 1'b1;
    tick();
    chk("ar_idle_busy", 32'(busy_o), 32'h0);
    chk("ar_idle_set", 32'(set_o), 32'h0);
    values = 16'h0042; permit = 1'b1;
    tick();
    permit = 1'b0;
    chk("ar2_c1_busy", 32'(busy_o), 32'h1);
    tick();
    chk("ar2_c2_set", 32'(set_o), 32'h0042);
    chk("ar2_c2_reset", 32'(reset_o), 32'hFFBD);
    tick();
    tick();
    chk("ar2_c4_done", 32'(done_o), 32'h1);
    tick();

    // DIGITS=6, PULSE_CYCLES=1
    vb = 24'h235959; pb = 1'b1;
    tick();
    pb = 1'b0;
    chk("p6_c1_busy", 32'(busy_b), 32'h1);
    chk("p6_c1_set", 32'(set_b), 32'h0);
    tick();
    chk("p6_c2_set", 32'(set_b), 32'h235959);
    chk("p6_c2_reset", 32'(reset_b), 32'hDCA6A6);
    tick();
    chk("p6_c3_set", 32'(set_b), 32'h0);
    chk("p6_c3_done", 32'(done_b), 32'h1);
    tick();
    chk("p6_c4_done", 32'(done_b), 32'h0);
    chk("p6_c4_busy", 32'(busy_b), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
